// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   General-purpose register file with a per-register busy-bit scoreboard.
//   Issue logic reserves a destination register and the writeback write
//   releases it. There is one write port and two read ports, and each read
//   port can optionally bypass write data issued in the same cycle.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   wr_en/wr_addr/wr_data  write port (out-of-range addresses are ignored)
//   rd_addr_a/b            read indices
//   rd_data_a/b            read data (combinational, 0 when out of range)
//   rd_busy_a/b            busy bit of the addressed register (combinational)
//   rsv_en/rsv_addr        reservation request
//   rsv_ok                 reservation accepted this cycle (combinational)
//   flush                  clear every busy bit at the next edge
//   busy_vec               registered busy bits, bit i = register i
//   reg_dump               registered contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    NUM_REGS    = 8,
    parameter int                    BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int                   ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [ADDR_W-1:0]              rd_addr_a,
    input  logic [ADDR_W-1:0]              rd_addr_b,
    output logic [DATA_WIDTH-1:0]          rd_data_a,
    output logic [DATA_WIDTH-1:0]          rd_data_b,
    output logic                           rd_busy_a,
    output logic                           rd_busy_b,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic                           rsv_ok,
    input  logic                           flush,
    output logic [NUM_REGS-1:0]            busy_vec,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_dump
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic                  wr_valid;
    logic                  rsv_busy;

    // NUM_REGS need not be a power of two, so the top address codes may be unused.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < (ADDR_W+1)'(NUM_REGS);
    endfunction

    // Writes are gated by reset so that nothing commits or bypasses while reset is held.
    assign wr_valid = reset & wr_en & in_range(wr_addr);

    always_comb begin
        rsv_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsv_addr == ADDR_W'(i)) rsv_busy = busy_q[i];
        end
    end

    // A busy register can be re-reserved in the cycle where its writeback lands.
    assign rsv_ok = reset & rsv_en & ~flush & in_range(rsv_addr) &
                    (~rsv_busy | (wr_en & (wr_addr == rsv_addr)));

    always_comb begin
        rd_data_a = '0;
        rd_busy_a = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = regs_q[i];
                rd_busy_a = busy_q[i];
            end
        end
        if ((BYPASS != 0) && wr_valid && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = '0;
        rd_busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = regs_q[i];
                rd_busy_b = busy_q[i];
            end
        end
        if ((BYPASS != 0) && wr_valid && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end
    end

    // Priority on a busy bit: flush > reservation > writeback release.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_valid && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
                busy_d[i] = 1'b0;
            end
            if (rsv_ok && (rsv_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
            if (flush) busy_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            busy_q <= busy_d;
            regs_q <= regs_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dump
        assign reg_dump[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Three instances share one stimulus stream:
//     0: 8 registers, bypass on
//     1: 8 registers, bypass off
//     2: 6 registers, bypass on
//   A behavioural array model predicts every output each cycle. A table of
//   directed vectors, written out by hand, also checks instance 0.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic        flush;

    logic [15:0]  o_rda  [3];
    logic [15:0]  o_rdb  [3];
    logic         o_ba   [3];
    logic         o_bb   [3];
    logic         o_ok   [3];
    logic [7:0]   o_bv   [3];
    logic [127:0] o_dump [3];
    logic [7:0]   bv8_0, bv8_1;
    logic [5:0]   bv6;
    logic [127:0] dump8_0, dump8_1;
    logic [95:0]  dump6;

    assign o_bv[0]   = bv8_0;
    assign o_bv[1]   = bv8_1;
    assign o_bv[2]   = {2'b00, bv6};
    assign o_dump[0] = dump8_0;
    assign o_dump[1] = dump8_1;
    assign o_dump[2] = {32'h0, dump6};

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_WIDTH(16), .NUM_REGS(8), .BYPASS(1), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(o_rda[0]), .rd_data_b(o_rdb[0]),
        .rd_busy_a(o_ba[0]), .rd_busy_b(o_bb[0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(o_ok[0]), .flush(flush), .busy_vec(bv8_0), .reg_dump(dump8_0));

    regfile_scoreboard #(.DATA_WIDTH(16), .NUM_REGS(8), .BYPASS(0), .RESET_VALUE(16'h0000)) dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(o_rda[1]), .rd_data_b(o_rdb[1]),
        .rd_busy_a(o_ba[1]), .rd_busy_b(o_bb[1]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(o_ok[1]), .flush(flush), .busy_vec(bv8_1), .reg_dump(dump8_1));

    regfile_scoreboard #(.DATA_WIDTH(16), .NUM_REGS(6), .BYPASS(1), .RESET_VALUE(16'h0000)) dut6 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(o_rda[2]), .rd_data_b(o_rdb[2]),
        .rd_busy_a(o_ba[2]), .rd_busy_b(o_bb[2]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(o_ok[2]), .flush(flush), .busy_vec(bv6), .reg_dump(dump6));

    // ---------------- reference model ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          nregs [3] = '{8, 8, 6};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] mregs [3][8];
    bit          mbusy [3][8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                mregs[k][i] = 16'h0000;
                mbusy[k][i] = 1'b0;
            end
    endtask

    function automatic bit m_wr_hits(int k, logic [2:0] a);
        return reset && wr_en && int'(wr_addr) < nregs[k] && wr_addr == a;
    endfunction

    function automatic logic [15:0] m_rd(int k, logic [2:0] a);
        if (int'(a) >= nregs[k]) return 16'h0000;
        if (byp[k] && m_wr_hits(k, a)) return wr_data;
        return mregs[k][a];
    endfunction

    function automatic logic m_busy(int k, logic [2:0] a);
        if (int'(a) >= nregs[k]) return 1'b0;
        if (byp[k] && m_wr_hits(k, a)) return 1'b0;
        return mbusy[k][a];
    endfunction

    function automatic logic m_ok(int k);
        if (!reset || !rsv_en || flush || int'(rsv_addr) >= nregs[k]) return 1'b0;
        return !mbusy[k][rsv_addr] || (wr_en && wr_addr == rsv_addr);
    endfunction

    function automatic logic [7:0] m_bv(int k);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < nregs[k]; i++) v[i] = mbusy[k][i];
        return v;
    endfunction

    function automatic logic [127:0] m_dump(int k);
        logic [127:0] v = '0;
        for (int i = 0; i < nregs[k]; i++) v[i*16 +: 16] = mregs[k][i];
        return v;
    endfunction

    task automatic model_edge();
        bit ok [3];
        if (!reset) return;
        for (int k = 0; k < 3; k++) ok[k] = m_ok(k);
        for (int k = 0; k < 3; k++) begin
            if (wr_en && int'(wr_addr) < nregs[k]) begin
                mregs[k][wr_addr] = wr_data;
                mbusy[k][wr_addr] = 1'b0;
            end
            if (ok[k]) mbusy[k][rsv_addr] = 1'b1;
            if (flush) for (int i = 0; i < 8; i++) mbusy[k][i] = 1'b0;
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_data_a[%0d]", k), o_rda[k], m_rd(k, rd_addr_a));
            chk($sformatf("rd_data_b[%0d]", k), o_rdb[k], m_rd(k, rd_addr_b));
            chk($sformatf("rd_busy_a[%0d]", k), o_ba[k], m_busy(k, rd_addr_a));
            chk($sformatf("rd_busy_b[%0d]", k), o_bb[k], m_busy(k, rd_addr_b));
            chk($sformatf("rsv_ok[%0d]", k), o_ok[k], m_ok(k));
            chk($sformatf("busy_vec[%0d]", k), o_bv[k], m_bv(k));
            chk($sformatf("reg_dump[%0d]", k), o_dump[k], m_dump(k));
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase of the next cycle.
    task automatic step();
        #2;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        rsv_en = 1'b0; rsv_addr = 3'd0; flush = 1'b0;
    endtask

    // ---------------- directed vectors (instance 0, plus bypass-off port a) ----------------
    typedef struct {
        logic        we;  logic [2:0] wa; logic [15:0] wd;
        logic [2:0]  ra;  logic [2:0] rb;
        logic        re;  logic [2:0] radr; logic fl;
        logic [15:0] e_a; logic [15:0] e_b; logic e_ba; logic e_ok;
        logic [7:0]  e_bv; logic [15:0] e_nba;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'hBEEF};
        vecs[2]  = '{1'b1, 3'd5, 16'h0001, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[3]  = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0001};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 3'd2, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'h00, 16'h0000};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 3'd2, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 8'h04, 16'h0000};
        vecs[6]  = '{1'b1, 3'd2, 16'h00AA, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 16'h00AA, 16'hBEEF, 1'b0, 1'b0, 8'h04, 16'h0000};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 16'h00AA, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h00AA};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b1, 3'd4, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'h00, 16'h0000};
        vecs[9]  = '{1'b1, 3'd4, 16'h4444, 3'd4, 3'd3, 1'b1, 3'd4, 1'b0, 16'h4444, 16'hBEEF, 1'b0, 1'b1, 8'h10, 16'h0000};
        vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b0, 3'd0, 1'b0, 16'h4444, 16'hBEEF, 1'b1, 1'b0, 8'h10, 16'h4444};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd3, 1'b1, 3'd1, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'h10, 16'h0000};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd3, 1'b1, 3'd6, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 8'h12, 16'h0000};
        vecs[13] = '{1'b1, 3'd6, 16'hCAFE, 3'd6, 3'd3, 1'b1, 3'd0, 1'b1, 16'hCAFE, 16'hBEEF, 1'b0, 1'b0, 8'h52, 16'h0000};
        vecs[14] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd3, 1'b0, 3'd0, 1'b0, 16'hCAFE, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'hCAFE};

        // ---- reset held: everything at reset value, rsv_ok low despite requests ----
        reset = 1'b0;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF;
        rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        rsv_en = 1'b1; rsv_addr = 3'd2;
        #1;
        chk("reset_rsv_ok", o_ok[0], 1'b0);
        chk("reset_dump", o_dump[0], 128'h0);
        chk("reset_busy_vec", o_bv[0], 8'h00);
        chk("reset_rd_a", o_rda[0], 16'h0000);
        step();
        step();

        // ---- directed table ----
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
            rsv_en = vecs[i].re; rsv_addr = vecs[i].radr; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d rd_data_a", i), o_rda[0], vecs[i].e_a);
            chk($sformatf("vec%0d rd_data_b", i), o_rdb[0], vecs[i].e_b);
            chk($sformatf("vec%0d rd_busy_a", i), o_ba[0], vecs[i].e_ba);
            chk($sformatf("vec%0d rsv_ok", i), o_ok[0], vecs[i].e_ok);
            chk($sformatf("vec%0d busy_vec", i), o_bv[0], vecs[i].e_bv);
            chk($sformatf("vec%0d nobypass rd_data_a", i), o_rda[1], vecs[i].e_nba);
            step();
        end
        idle_inputs();
        #1;
        chk("dump_r3", o_dump[0][63:48], 16'hBEEF);
        chk("dump_r6", o_dump[0][111:96], 16'hCAFE);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rsv_en    = 1'($urandom_range(0, 1));
            rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 7) == 0);
            step();
        end

        // ---- asynchronous reset mid-cycle with R1 busy ----
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 3'd1;
        step();
        rsv_en = 1'b0;
        #1;
        chk("pre_reset_busy_r1", o_bv[0][1], 1'b1);
        reset = 1'b0;
        model_reset();
        rsv_en = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_busy_vec[%0d]", k), o_bv[k], 8'h00);
            chk($sformatf("async_dump[%0d]", k), o_dump[k], 128'h0);
            chk($sformatf("async_rsv_ok[%0d]", k), o_ok[k], 1'b0);
        end
        step();
        reset = 1'b1;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
        step();
        idle_inputs();
        rd_addr_a = 3'd1;
        #1;
        chk("post_reset_writeback", o_rda[0], 16'h7777);
        step();

        // ---- out-of-range index 7 on the 6-register instance ----
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h5555;
        rsv_en = 1'b1; rsv_addr = 3'd7;
        rd_addr_a = 3'd7; rd_addr_b = 3'd7;
        #1;
        chk("oor_rsv_ok", o_ok[2], 1'b0);
        chk("oor_rd_a", o_rda[2], 16'h0000);
        chk("oor_rd_b", o_rdb[2], 16'h0000);
        chk("oor_busy_a", o_ba[2], 1'b0);
        step();
        idle_inputs();
        rd_addr_a = 3'd7;
        #1;
        chk("oor_busy_vec", o_bv[2], m_bv(2));
        chk("oor_dump", o_dump[2], m_dump(2));
        chk("oor_rd_after", o_rda[2], 16'h0000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
